seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 17 +
 rtl/div_datapath.sv | 99 +++++++++
 rtl/seq_divider.sv | 89 ++++++++
 tb/tb_seq_divider.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

  localparam int WIDTH = 16;
  localparam int ITERS = 16;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/div_datapath.sv
// Divider datapath: operand, R/Q and iteration-counter registers plus the restoring subtractor.
// Latency: one shift-subtract step per cycle with step asserted; loads take effect on the next edge.
// Backpressure: none; acts only on the load_a/load_b/step controls from the controller.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   data_in          shared operand bus (dividend on load_a, divisor on load_b)
//   load_a, load_b   capture dividend / divisor, step performs one iteration
//   zero_skip        divisor on data_in is zero and RUN is to be skipped
//   last_iter        current step completes the final iteration
//   quotient, remainder, div_by_zero   registered results
//
// Optional feature: DIV_ZERO_DETECT_EN enables the zero-divisor short-cut and flag.
module div_datapath
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             step,
  output logic             zero_skip,
  output logic             last_iter,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] rem_sh;
  logic             carry;
  logic [WIDTH:0]   diff;
  logic             ge;

  // {R,Q} shifted left by one; the bit shifted out of R is kept as carry so
  // that a 17-bit difference is enough: with the carry set the shifted value
  // is at least 2^16 > divisor, and the low 16 bits of diff are still correct.
  assign carry  = rem[WIDTH-1];
  assign rem_sh = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign diff   = {1'b0, rem_sh} - {1'b0, divisor};
  assign ge     = carry | ~diff[WIDTH];

  assign last_iter = (cnt == CNT_W'(1));

`ifdef DIV_ZERO_DETECT_EN
  assign zero_skip = (data_in == '0);
`else
  assign zero_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      cnt     <= '0;
    end else if (load_a) begin
      quo <= data_in;
      rem <= '0;
    end else if (load_b) begin
      divisor <= data_in;
      cnt     <= CNT_W'(ITERS);
      if (zero_skip) begin
        // Short-cut result matches what 16 steps against a zero divisor yield.
        quo <= '1;
        rem <= quo;
      end
    end else if (step) begin
      rem <= ge ? diff[WIDTH-1:0] : rem_sh;
      quo <= {quo[WIDTH-2:0], ge};
      cnt <= cnt - CNT_W'(1);
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dbz;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz <= 1'b0;
    end else if (load_a) begin
      dbz <= 1'b0;
    end else if (load_b) begin
      dbz <= zero_skip;
    end
  end
  assign div_by_zero = dbz;
`else
  assign div_by_zero = 1'b0;
`endif

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/seq_divider.sv
// 16-bit unsigned sequential restoring divider: controller FSM driving div_datapath.
// Latency: done visible at the 18th rising edge after the start edge (2nd with zero-divisor short-cut).
// Backpressure: start is accepted only in IDLE or DONE and ignored while busy.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        begin a division (dividend on data_in this cycle, divisor next cycle)
//   data_in      shared operand bus
//   busy         high in LOAD_B and RUN
//   done         high in DONE, results held until the next accepted start
//   quotient, remainder, div_by_zero   registered results
//
// Optional feature: DIV_ZERO_DETECT_EN skips RUN for a zero divisor and raises div_by_zero.
module seq_divider
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t state;
  state_t state_next;

  logic load_a;
  logic load_b;
  logic step;
  logic zero_skip;
  logic last_iter;

  div_datapath u_datapath (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .load_a      (load_a),
    .load_b      (load_b),
    .step        (step),
    .zero_skip   (zero_skip),
    .last_iter   (last_iter),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load_a     = 1'b1;
          state_next = LOAD_B;
        end
      end
      LOAD_B: begin
        load_b     = 1'b1;
        state_next = zero_skip ? DONE : RUN;
      end
      RUN: begin
        step = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Decoded straight from the state register, so no input reaches these.
  assign busy = (state == LOAD_B) || (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus randomized divisions against an arithmetic model.
// A value "visible at edge N" is the one present just before rising edge N (start edge = edge 0).
module tb_seq_divider;

`ifdef DIV_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] data_in;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  // Model state for the operation in flight.
  bit          in_op = 1'b0;
  int          k     = 0;
  int          lat   = 18;
  logic [15:0] exp_q;
  logic [15:0] exp_r;
  logic        exp_dbz;

  always #5 clk = ~clk;

  seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_expect(input logic [15:0] a, input logic [15:0] b);
    if (b == 16'd0) begin
      exp_q = 16'hFFFF;
      exp_r = a;
    end else begin
      exp_q = a / b;
      exp_r = a % b;
    end
    exp_dbz = ZD && (b == 16'd0);
    lat     = (ZD && (b == 16'd0)) ? 2 : 18;
  endtask

  // Compare process: every negedge, outputs vs the model's cycle-by-cycle expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_op) begin
        if (k + 1 >= lat) begin
          chk("done", 32'(done), 32'd1);
          chk("busy", 32'(busy), 32'd0);
          chk("quotient", 32'(quotient), 32'(exp_q));
          chk("remainder", 32'(remainder), 32'(exp_r));
          chk("div_by_zero", 32'(div_by_zero), 32'(exp_dbz));
        end else begin
          chk("done_early", 32'(done), 32'd0);
          chk("busy_run", 32'(busy), 32'd1);
        end
      end else begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_quotient", 32'(quotient), 32'd0);
        chk("idle_remainder", 32'(remainder), 32'd0);
      end
    end
  end

  task automatic do_div(input logic [15:0] a, input logic [15:0] b, input bit repulse, input int extra);
    @(negedge clk);
    start   = 1'b1;
    data_in = a;
    @(posedge clk);                 // edge 0
    set_expect(a, b);
    k     = 0;
    in_op = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    data_in = b;
    for (int e = 1; e < lat + extra; e++) begin
      @(posedge clk);
      k = e;
      @(negedge clk);
      data_in = 16'($urandom);
      start   = repulse && (lat > 2) && (e == 4 || e == 9);
    end
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_quotient"}, 32'(quotient), 32'd0);
    chk({tag, "_remainder"}, 32'(remainder), 32'd0);
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int          sel;

    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = 16'd0;
    #1;
    chk_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases with hand-computed results.
    do_div(16'd100, 16'd7, 1'b0, 2);
    chk("q_100_7", 32'(quotient), 32'd14);
    chk("r_100_7", 32'(remainder), 32'd2);
    chk("dbz_100_7", 32'(div_by_zero), 32'd0);

    do_div(16'd65535, 16'd1, 1'b0, 1);
    chk("q_65535_1", 32'(quotient), 32'd65535);
    chk("r_65535_1", 32'(remainder), 32'd0);

    do_div(16'd5, 16'd10, 1'b0, 1);
    chk("q_5_10", 32'(quotient), 32'd0);
    chk("r_5_10", 32'(remainder), 32'd5);

    do_div(16'd1234, 16'd0, 1'b0, 2);
    chk("q_1234_0", 32'(quotient), 32'hFFFF);
    chk("r_1234_0", 32'(remainder), 32'd1234);
    chk("dbz_1234_0", 32'(div_by_zero), ZD ? 32'd1 : 32'd0);

    do_div(16'd200, 16'd9, 1'b1, 2);
    chk("q_200_9", 32'(quotient), 32'd22);
    chk("r_200_9", 32'(remainder), 32'd2);

    // Reset asserted in the middle of RUN.
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'd300;
    @(posedge clk);
    set_expect(16'd300, 16'd7);
    k     = 0;
    in_op = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    data_in = 16'd7;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      k = e;
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    in_op = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);   // compare process confirms no done appears

    do_div(16'd50, 16'd5, 1'b0, 1);
    chk("q_50_5", 32'(quotient), 32'd10);
    chk("r_50_5", 32'(remainder), 32'd0);

    // Back-to-back: accepted straight out of DONE.
    do_div(16'd81, 16'd9, 1'b0, 1);
    chk("q_81_9", 32'(quotient), 32'd9);
    chk("r_81_9", 32'(remainder), 32'd0);

    // Randomized divisions.
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      ra  = (sel == 5) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      case (sel)
        0:       rb = 16'd0;
        1:       rb = 16'd1;
        2:       rb = 16'($urandom_range(1, 15));
        3:       rb = 16'hFFFF;
        default: rb = 16'($urandom);
      endcase
      do_div(ra, rb, ($urandom_range(0, 3) == 0), $urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
